// File: rtl/crc_pkg.sv
// ============================================================================
// crc_pkg : shared widths, polynomial/init constants and types for the CRC block
// Revision: 1.0
// ============================================================================
`default_nettype none

package crc_pkg;

  localparam int unsigned CRC_WIDTH = 64;

  typedef logic [CRC_WIDTH-1:0] crc_t;

  // CRC-64-ECMA-182, implicit x^64 term omitted
  localparam crc_t CRC_POLY_ECMA = 64'h42F0E1EBA9EA3693;
  localparam crc_t CRC_INIT_ZERO = 64'h0;

endpackage : crc_pkg

`default_nettype wire

// File: rtl/crc_next_bit.sv
// ============================================================================
// crc_next_bit : one-bit Galois LFSR step, feedback taken from the MSB
// Revision: 1.0
// ============================================================================
`default_nettype none

module crc_next_bit
  import crc_pkg::*;
(
  input  logic [CRC_WIDTH-1:0] cur,
  input  logic                 din,
  input  logic [CRC_WIDTH-1:0] poly,
  output logic [CRC_WIDTH-1:0] nxt
);

  logic w_fb;

  assign w_fb = cur[CRC_WIDTH-1] ^ din;
  assign nxt  = {cur[CRC_WIDTH-2:0], 1'b0} ^ (w_fb ? poly : {CRC_WIDTH{1'b0}});

endmodule : crc_next_bit

`default_nettype wire

// File: rtl/crc.sv
// ============================================================================
// crc : serial CRC register, one message bit per rising clock edge, MSB-first
// Revision: 1.0
// ============================================================================
`default_nettype none

module crc
  import crc_pkg::*;
#(
  parameter logic [CRC_WIDTH-1:0] POLY = CRC_POLY_ECMA,
  parameter logic [CRC_WIDTH-1:0] INIT = CRC_INIT_ZERO
) (
  input  logic                 CLK,
  input  logic                 RST,
  output logic [CRC_WIDTH-1:0] CRC,
  input  logic                 DATA
);

  crc_t r_crc;
  crc_t w_nxt;

  crc_next_bit u_next (
    .cur  (r_crc),
    .din  (DATA),
    .poly (POLY),
    .nxt  (w_nxt)
  );

  // DATA only reaches the register through the clocked path, so X on DATA during reset is harmless
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_crc <= INIT;
    end else begin
      r_crc <= w_nxt;
    end
  end

  assign CRC = r_crc;

endmodule : crc

`default_nettype wire

// File: tb/tb_crc.sv
// ============================================================================
// tb_crc : self-checking bench for crc against a polynomial long-division model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_crc;

  localparam logic [63:0] C_POLY = 64'h42F0E1EBA9EA3693;

  logic        CLK;
  logic        RST;
  logic [63:0] CRC;
  logic        DATA;

  int checks = 0;
  int errors = 0;

  crc dut (
    .CLK  (CLK),
    .RST  (RST),
    .CRC  (CRC),
    .DATA (DATA)
  );

  // first rising edge at t=10
  initial CLK = 1'b1;
  always #5 CLK = ~CLK;

  // Remainder of M(x) * x^64 divided by G(x) = x^64 + POLY, using the first n
  // message bits (MSB of m first), computed by textbook long division.
  function automatic logic [63:0] ref_crc(input logic [255:0] m, input int n);
    logic [64:0] rem;
    logic        b;
    rem = '0;
    for (int i = 0; i < n + 64; i++) begin
      b   = (i < n) ? m[255 - i] : 1'b0;
      rem = {rem[63:0], b};
      if (rem[64]) rem = rem ^ {1'b1, C_POLY};
    end
    return rem[63:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] exp);
    checks++;
    assert (CRC === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, CRC, exp);
    end
  endtask

  // drive one bit, wait for the edge, then sample away from it
  task automatic step(input logic d);
    DATA = d;
    @(posedge CLK);
    #1;
  endtask

  // async reset pulse between edges; call from posedge+1
  task automatic pulse_reset();
    #2 RST = 1'b0;
    DATA = 1'bx;
    #1 check("reset_pulse", 64'h0);
    #1 RST = 1'b1;
  endtask

  task automatic run_msg(input string tag, input logic [255:0] m, output logic [63:0] res);
    int bad;
    bad = 0;
    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      step(m[255 - i]);
      checks++;
      assert (CRC === ref_crc(m, i + 1)) else begin
        errors++;
        bad++;
        if (bad <= 4)
          $error("FAIL %s bit=%0d observed=%h expected=%h", tag, i, CRC, ref_crc(m, i + 1));
      end
    end
    res = CRC;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [255:0] ma, mb, mc;
    logic [63:0]  ra, rb, rc;

    RST  = 1'b0;
    DATA = 1'bx;
    #1 check("reset_async_x_data", 64'h0);
    #1 RST = 1'b1;
    #6 DATA = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1 check("zero_fixed_point", 64'h0);
    end

    step(1'b1);
    check("single_one", 64'h42F0E1EBA9EA3693);
    step(1'b0);
    check("shift_no_fb", 64'h85E1C3D753D46D26);
    step(1'b0);
    check("shift_msb_fb", 64'h493366450E42ECDF);

    // mid-stream reset, held across an edge with undriven DATA
    #3 RST = 1'b0;
    DATA = 1'bx;
    #1 check("midstream_reset", 64'h0);
    @(posedge CLK);
    #1 check("reset_hold_edge", 64'h0);
    RST = 1'b1;
    step(1'b1);
    check("first_bit_after_release", 64'h42F0E1EBA9EA3693);

    for (int p = 0; p < 2; p++) begin
      ma = rand256();
      mb = rand256();
      mc = ma ^ mb;
      run_msg("rand_a", ma, ra);
      run_msg("rand_b", mb, rb);
      run_msg("rand_axb", mc, rc);
      check("linearity", ra ^ rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_crc

`default_nettype wire

// File: doc/crc.md
CRC -- requirements
Module: crc

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low, using the codebase port names CLK (clock) and RST (reset).
REQ-002 Parameter list, one per line (name, default, meaning):
- POLY, 64'h42F0E1EBA9EA3693, generator polynomial (CRC-64-ECMA-182), implicit x^64 term omitted.
- INIT, 64'h0000000000000000, register value loaded on reset.
REQ-003 Port list, one per line (name, direction, width, meaning):
- CLK, input, 1, rising-edge clock.
- RST, input, 1, asynchronous active-low reset.
- CRC, output, 64, current CRC register value.
- DATA, input, 1, serial message bit, MSB-first.
REQ-004 Port order SHALL be CLK, RST, CRC, DATA, so positional instantiation connects correctly.

Function
REQ-005 The block SHALL be a serial Galois LFSR that consumes exactly one DATA bit on every rising CLK edge while RST=1; there is no enable or valid input.
REQ-006 Per edge: fb = CRC[63] XOR DATA.
REQ-007 Next state: next = {CRC[62:0], 1'b0} XOR (fb ? POLY : 64'h0).
REQ-008 CRC SHALL be the register output directly: no output reflection, no final XOR, no combinational path from DATA to CRC.
REQ-009 Latency SHALL be one cycle: a bit sampled at edge n is reflected in CRC immediately after edge n.
REQ-010 The update SHALL be modulo-2 (XOR only) and fixed at 64 bits; bit 63 is discarded on each shift.
REQ-011 With CRC=0 and DATA=0, CRC SHALL remain 0 (zero is a fixed point).
REQ-012 The next-state function SHALL be linear over GF(2): crc(A XOR B) = crc(A) XOR crc(B) when INIT=0.

Reset
REQ-013 RST=0 SHALL force CRC to INIT immediately, without waiting for a CLK edge.
REQ-014 CRC SHALL hold INIT while RST=0, regardless of CLK or DATA.
REQ-015 Reset asserted mid-message SHALL discard all accumulated state.
REQ-016 The first bit consumed after release SHALL be the bit sampled at the first rising CLK edge with RST=1.
REQ-017 DATA SHALL be ignored while RST=0, so an undriven (X) DATA during reset does not corrupt CRC.

Structure
REQ-018 A shared package crc_pkg SHALL hold:
- CRC_WIDTH=64.
- CRC_POLY_ECMA=64'h42F0E1EBA9EA3693.
- CRC_INIT_ZERO=64'h0.
- A 64-bit crc_t typedef.
REQ-019 The combinational next-state function SHALL be one sub-module, crc_next_bit (inputs cur[63:0], din, poly; output nxt[63:0]).
REQ-020 The top-level crc SHALL contain only the asynchronous-reset register around crc_next_bit.

Verification
REQ-021 Reset: RST=0 at t=0, released at t=2; DATA=0 from t=8 -> CRC=64'h0 during reset and on every edge thereafter.
REQ-022 Single one: from 0, DATA=1 for one edge -> CRC=64'h42F0E1EBA9EA3693.
REQ-023 Continuing with DATA=0:
- next edge -> CRC=64'h85E1C3D753D46D26.
- following edge -> CRC=64'h493366450E42ECDF (feedback taken from MSB).
REQ-024 Async reset mid-stream: pulse RST low between edges while CRC is nonzero -> CRC=0 before the next CLK edge; the next DATA=1 edge -> CRC=64'h42F0E1EBA9EA3693.
REQ-025 Random 256-bit messages: CRC matches a bit-serial reference model after every edge, and linearity (REQ-012) holds for message pairs.
